// File: rtl/mem_arbiter_if.sv
// picorv32-style native memory bus: one request channel plus its ready/rdata return.
// The arbiter takes two of these as slave ports and drives one downstream as master.
`timescale 1ns/1ps

interface mem_arbiter_if;
  logic        valid;
  logic        instr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, instr, wstrb, wdata, addr, input ready, rdata);
  modport slave  (input valid, instr, wstrb, wdata, addr, output ready, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the native memory bus, with a per-transaction
// timeout that completes a stalled access with ERR_DATA and a one-cycle bus_error.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  mem_arbiter_if.slave         m0,
  mem_arbiter_if.slave         m1,
  mem_arbiter_if.master        mem,
  output logic                 bus_error,
  output logic [1:0]           grant
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;

  logic        busy, expired, done;
  logic        mem_valid_o, mem_instr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o, mem_addr_o, done_rdata;

  assign busy       = (state_q != IDLE);
  assign expired    = (cnt_q == CNT_LAST);
  assign done       = busy && (mem.ready || expired);
  // A coinciding mem_ready wins over the timeout: real data, no error.
  assign bus_error  = busy && expired && !mem.ready;
  assign done_rdata = mem.ready ? mem.rdata : ERR_DATA;

  assign grant     = {state_q == BUSY1, state_q == BUSY0};
  assign m0.ready  = done && (state_q == BUSY0);
  assign m1.ready  = done && (state_q == BUSY1);
  assign m0.rdata  = m0.ready ? done_rdata : 32'h0;
  assign m1.rdata  = m1.ready ? done_rdata : 32'h0;

  // NOTE: every variable gets a default at the top of an always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_valid_o = 1'b0;
    mem_instr_o = 1'b0;
    mem_wstrb_o = 4'h0;
    mem_wdata_o = 32'h0;
    mem_addr_o  = 32'h0;
    case (state_q)
      BUSY0: begin
        mem_valid_o = 1'b1;
        mem_instr_o = m0.instr;
        mem_wstrb_o = m0.wstrb;
        mem_wdata_o = m0.wdata;
        mem_addr_o  = m0.addr;
      end
      BUSY1: begin
        mem_valid_o = 1'b1;
        mem_instr_o = m1.instr;
        mem_wstrb_o = m1.wstrb;
        mem_wdata_o = m1.wdata;
        mem_addr_o  = m1.addr;
      end
      default: ;
    endcase
  end

  assign mem.valid = mem_valid_o;
  assign mem.instr = mem_instr_o;
  assign mem.wstrb = mem_wstrb_o;
  assign mem.wdata = mem_wdata_o;
  assign mem.addr  = mem_addr_o;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 16'h0;
        // On a tie the master that was not served last wins.
        if (m0.valid && m1.valid) state_d = last_q ? BUSY0 : BUSY1;
        else if (m0.valid)        state_d = BUSY0;
        else if (m1.valid)        state_d = BUSY1;
      end
      BUSY0, BUSY1: begin
        if (done) begin
          state_d = IDLE;
          last_d  = (state_q == BUSY1);
          cnt_d   = 16'h0;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a transaction-level model.
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       bus_error;
  logic [1:0] grant;

  mem_arbiter_if m0_if ();
  mem_arbiter_if m1_if ();
  mem_arbiter_if mem_if ();

  mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem       (mem_if),
    .bus_error (bus_error),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream responder. 0: never ready, 1: registered one-cycle ready,
  // 2: random ready, 3: ready forced by the directed sequence.
  int          mem_mode = 0;
  logic [31:0] rd_val = 32'h0;
  logic        force_rdy = 1'b0;
  logic        rsp_v, rsp_r, rsp_n;

  initial begin
    mem_if.ready = 1'b0;
    mem_if.rdata = 32'h0;
    forever begin
      @(negedge clk);
      rsp_v = mem_if.valid;
      rsp_r = mem_if.ready;
      @(posedge clk);
      #2;
      case (mem_mode)
        1:       rsp_n = rsp_v && !rsp_r;
        2:       rsp_n = ($urandom_range(0, 3) == 0);
        3:       rsp_n = force_rdy;
        default: rsp_n = 1'b0;
      endcase
      mem_if.ready = rsp_n;
      mem_if.rdata = rsp_n ? ((mem_mode == 2) ? $urandom : rd_val) : 32'h0;
    end
  end

  // Transaction-level reference: who owns the bus, how many BUSY cycles it has had,
  // and who was served last. Outputs are derived from these on every cycle.
  int          own = -1;
  int          age = 0;
  bit          last_m = 1'b1;
  bit          m_done, m_timed;
  logic [1:0]  e_grant;
  logic [68:0] e_req;
  logic [31:0] e_rd;

  always @(negedge clk) begin
    if (!resetn) begin
      own = -1; age = 0; last_m = 1'b1;
      check("rst_ctl", {75'h0, mem_if.valid, grant, m0_if.ready, m1_if.ready, bus_error}, 80'h0);
      check("rst_req", {11'h0, mem_if.instr, mem_if.wstrb, mem_if.wdata, mem_if.addr}, 80'h0);
      check("rst_rdata", {16'h0, m0_if.rdata, m1_if.rdata}, 80'h0);
    end else begin
      m_done  = (own >= 0) && (mem_if.ready === 1'b1 || age == int'(TO));
      m_timed = m_done && (mem_if.ready !== 1'b1);
      e_grant = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
      e_req   = (own == 0) ? {m0_if.instr, m0_if.wstrb, m0_if.wdata, m0_if.addr} :
                (own == 1) ? {m1_if.instr, m1_if.wstrb, m1_if.wdata, m1_if.addr} : 69'h0;
      e_rd    = m_timed ? ERR : mem_if.rdata;
      check("mdl_valid", {79'h0, mem_if.valid}, {79'h0, own >= 0});
      check("mdl_grant", {78'h0, grant}, {78'h0, e_grant});
      check("mdl_req", {11'h0, mem_if.instr, mem_if.wstrb, mem_if.wdata, mem_if.addr}, {11'h0, e_req});
      check("mdl_ready", {78'h0, m0_if.ready, m1_if.ready}, {78'h0, m_done && own == 0, m_done && own == 1});
      check("mdl_bus_error", {79'h0, bus_error}, {79'h0, m_timed});
      if (own != 0) check("mdl_m0_rdata_idle", {48'h0, m0_if.rdata}, 80'h0);
      else if (m_done) check("mdl_m0_rdata", {48'h0, m0_if.rdata}, {48'h0, e_rd});
      if (own != 1) check("mdl_m1_rdata_idle", {48'h0, m1_if.rdata}, 80'h0);
      else if (m_done) check("mdl_m1_rdata", {48'h0, m1_if.rdata}, {48'h0, e_rd});
      if (own < 0) begin
        if (m0_if.valid && m1_if.valid) own = last_m ? 0 : 1;
        else if (m0_if.valid)           own = 0;
        else if (m1_if.valid)           own = 1;
        age = (own >= 0) ? 1 : 0;
      end else if (m_done) begin
        last_m = (own == 1);
        own = -1;
        age = 0;
      end else begin
        age++;
      end
    end
  end

  task automatic set_m(input int m, input logic v, input logic ins, input logic [3:0] ws,
                       input logic [31:0] wd, input logic [31:0] ad);
    if (m == 0) begin
      m0_if.valid = v; m0_if.instr = ins; m0_if.wstrb = ws; m0_if.wdata = wd; m0_if.addr = ad;
    end else begin
      m1_if.valid = v; m1_if.instr = ins; m1_if.wstrb = ws; m1_if.wdata = wd; m1_if.addr = ad;
    end
  endtask

  task automatic rand_req(input int m);
    logic [3:0] ws;
    ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    set_m(m, 1'b1, 1'($urandom_range(0, 1)), ws, $urandom, $urandom);
  endtask

  logic [1:0] exp_g [13] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                             2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
  logic       r0, r1;

  initial begin
    set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) tick();
    check("reset_grant", {78'h0, grant}, 80'h0);
    check("reset_mem_valid", {79'h0, mem_if.valid}, 80'h0);
    resetn = 1'b1;

    // Single read from m0 with a registered-ready memory.
    tick();
    mem_mode = 1; rd_val = 32'h12345678;
    set_m(0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h100);
    tick(); @(negedge clk);
    check("rd_grant", {78'h0, grant}, {78'h0, 2'b01});
    check("rd_addr", {48'h0, mem_if.addr}, {48'h0, 32'h100});
    check("rd_not_ready_yet", {79'h0, m0_if.ready}, 80'h0);
    tick(); @(negedge clk);
    check("rd_ready", {79'h0, m0_if.ready}, {79'h0, 1'b1});
    check("rd_rdata", {48'h0, m0_if.rdata}, {48'h0, 32'h12345678});
    tick();
    set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("rd_idle_grant", {78'h0, grant}, 80'h0);
    check("rd_idle_valid", {79'h0, mem_if.valid}, 80'h0);

    // Write pass-through from m1.
    rd_val = 32'h0;
    set_m(1, 1'b1, 1'b0, 4'b0011, 32'hAABBCCDD, 32'h204);
    tick(); @(negedge clk);
    check("wr_grant", {78'h0, grant}, {78'h0, 2'b10});
    check("wr_fields", {11'h0, mem_if.instr, mem_if.wstrb, mem_if.wdata, mem_if.addr},
          {11'h0, 1'b0, 4'b0011, 32'hAABBCCDD, 32'h204});
    check("wr_m0_quiet", {79'h0, m0_if.ready}, 80'h0);
    tick(); @(negedge clk);
    check("wr_m1_ready", {78'h0, m0_if.ready, m1_if.ready}, {78'h0, 2'b01});
    tick();
    set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Timeout on an unmapped address.
    mem_mode = 0;
    set_m(0, 1'b1, 1'b0, 4'h0, 32'h0, 32'hF000_0000);
    for (int c = 1; c <= 8; c++) begin
      tick(); @(negedge clk);
      check($sformatf("to_ready_c%0d", c), {78'h0, m0_if.ready, bus_error}, {78'h0, c == 8, c == 8});
      if (c == 8) check("to_rdata", {48'h0, m0_if.rdata}, {48'h0, 32'hDEADBEEF});
    end
    tick();
    set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("to_idle_grant", {78'h0, grant}, 80'h0);

    // Ready arriving exactly on the timeout cycle.
    tick();
    mem_mode = 3; force_rdy = 1'b0; rd_val = 32'h0BADF00D;
    set_m(0, 1'b1, 1'b0, 4'h0, 32'h0, 32'hF000_0004);
    for (int c = 1; c <= 8; c++) begin
      tick();
      force_rdy = (c == 8);
      @(negedge clk);
      check($sformatf("col_ready_c%0d", c), {78'h0, m0_if.ready, bus_error}, {78'h0, c == 8, 1'b0});
      if (c == 8) check("col_rdata", {48'h0, m0_if.rdata}, {48'h0, 32'h0BADF00D});
    end
    tick();
    force_rdy = 1'b0;
    set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("col_idle_grant", {78'h0, grant}, 80'h0);

    // Reset while m1 is mid-transaction, then continuous contention from reset.
    tick();
    mem_mode = 0;
    set_m(1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h300);
    tick();
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_ctl", {76'h0, grant, mem_if.valid, m1_if.ready}, 80'h0);
    check("mid_rst_bus", {47'h0, bus_error, mem_if.addr}, 80'h0);
    set_m(0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h400);
    mem_mode = 1; rd_val = 32'h5555AAAA;
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check($sformatf("rr_grant_%0d", i), {78'h0, grant}, {78'h0, exp_g[i]});
      tick();
    end
    set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) tick();

    // Randomized traffic; masters hold a request until they see their ready.
    mem_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r0 = m0_if.ready;
      r1 = m1_if.ready;
      tick();
      if (!m0_if.valid || r0) begin
        if ($urandom_range(0, 2) != 0) rand_req(0);
        else set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
      if (!m1_if.valid || r1) begin
        if ($urandom_range(0, 2) != 0) rand_req(1);
        else set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
    end
    set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (TO + 3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, round-robin arbiter for the picorv32-style native memory bus, placed directly upstream of the memory controller and the wire-OR'ed peripheral bus. It accepts requests from two bus masters (e.g. CPU and a DMA/second core), grants one at a time, and forwards the granted master's request downstream. It returns the downstream `mem_ready`/`mem_rdata` to that master, and completes stalled transactions with an error word after a timeout.

## Interface
- `TIMEOUT`, default 255: downstream cycles without `mem_ready` before a forced completion; range 2..65535.
- `ERR_DATA`, default 32'hDEADBEEF: read data returned on a timed-out transaction.

- `clk` input 1: single system clock; all state on posedge.
- `resetn` input 1: reset, asynchronous, active-low.
- `m0_valid`, `m1_valid` input 1: master request.
- `m0_instr`, `m1_instr` input 1: instruction-fetch flag.
- `m0_wstrb`, `m1_wstrb` input 4: byte write strobes; 0 means read.
- `m0_wdata`, `m1_wdata` input 32: write data.
- `m0_addr`, `m1_addr` input 32: byte address.
- `m0_ready`, `m1_ready` output 1: transaction complete, one-cycle pulse.
- `m0_rdata`, `m1_rdata` output 32: read data, valid while the matching ready is high.
- `mem_valid` output 1: downstream request.
- `mem_instr` output 1, `mem_wstrb` output 4, `mem_wdata` output 32, `mem_addr` output 32: downstream request fields.
- `mem_ready` input 1: downstream completion (wire-OR of all slaves).
- `mem_rdata` input 32: downstream read data (wire-OR of all slaves).
- `bus_error` output 1: one-cycle pulse on timeout completion.
- `grant` output 2: one-hot owner; bit 0 = m0, bit 1 = m1, 0 when idle.

## Operation
- States: IDLE, BUSY0, BUSY1. Priority pointer `last` (1 bit) records the last master served.
- **IDLE:**
  - Neither master valid: stay in IDLE.
  - One master valid: go to that master's BUSY state.
  - Both masters valid: grant the master that is not `last`.
  - Request fields are sampled as live inputs; no capture register.
- **BUSYx, downstream fields:**
  - `mem_valid` = 1.
  - `mem_instr`/`mem_wstrb`/`mem_wdata`/`mem_addr` pass through combinationally from master x.
  - `grant[x]` = 1.
- **BUSYx, completion on `mem_ready`=1:**
  - Same cycle: `mx_ready`=1 and `mx_rdata`=`mem_rdata`.
  - Next cycle: go to IDLE, `last`<=x, timeout counter cleared.
- **BUSYx, timeout:** a 16-bit counter increments every BUSY cycle without `mem_ready`. When it equals `TIMEOUT-1` and `mem_ready`=0, the arbiter drives, in that same cycle:
  - `mx_ready`=1
  - `mx_rdata`=`ERR_DATA`
  - `bus_error`=1

  It then goes to IDLE exactly as for a normal completion.
- If `mem_ready` and the timeout coincide, this is a normal completion: real data, `bus_error`=0.
- **IDLE outputs:**
  - `mem_valid`=0.
  - All `mem_*` request fields = 0.
  - `grant`=0.
  - `mem_ready` is ignored.
- Non-granted master: `ready`=0 and `rdata`=0 at all times.
- A master dropping `valid` while granted violates the protocol. The arbiter keeps the grant until completion or timeout.
- **Reset:** asynchronous assertion at any time, including mid-transaction, gives:
  - state IDLE, `last`=1 (so m0 wins the first tie), counter 0.
  - every output 0.
  - An in-flight transaction is abandoned without a ready pulse.

## Timing
- Arbitration latency: a request seen in IDLE at edge N is on `mem_valid` during cycle N+1.
- The downstream memory controller registers ready, giving a 2-cycle master-visible latency from grant to ready for memory accesses.
- Every transaction is followed by exactly one IDLE cycle with `mem_valid`=0. This mandatory cycle lets the stale registered `mem_ready` from the previous transaction clear before the next grant. Back-to-back throughput is therefore one transaction per 3 cycles against memory.
- `mx_ready` and `bus_error` are combinational from state and `mem_ready`/counter; each is high for exactly one cycle per transaction.
- Maximum cycles in BUSY = `TIMEOUT`.

## Test plan
- **Single read:** m0 read to 0x100, memory returns 0x12345678 one cycle after `mem_valid` → `m0_ready` pulses once with `m0_rdata`=0x12345678, `grant`=01 during BUSY, then `grant`=00 for one cycle.
- **Contention:**
  - m0 and m1 both request continuously from reset → order m0, m1, m0, m1.
  - Each grant is separated by one IDLE cycle with `mem_valid`=0.
  - The 4 transactions take 12 cycles.
- **Write pass-through:** m1 writes wstrb=4'b0011, wdata=0xAABBCCDD, addr=0x204 → identical values on `mem_*` while `grant`=10; `m0_ready` stays 0.
- **Timeout:** `TIMEOUT`=8, m0 reads an unmapped address with `mem_ready` held 0 → on BUSY cycle 8 the arbiter asserts `m0_ready`=1, `m0_rdata`=0xDEADBEEF and `bus_error`=1. The next cycle is IDLE.
- **Timeout collision:** `mem_ready` asserted exactly on the timeout cycle → real data returned, `bus_error`=0.
- **Reset mid-transaction:** deassert `resetn` asynchronously in BUSY1 → all outputs 0 immediately, no `m1_ready` pulse. After release, with both requesting, m0 is granted first.
